parking_timer_sched: RTL

Shared one-second timebase and multi-channel countdown scheduler for the parking controller (gate-open hold, exit grace, alarm timeouts). Requesters ask for a duration in seconds. A round-robin arbiter accepts one request per cycle and loads it into that requester's channel counter. All channels decrement on a single internally generated 1 Hz tick. Each channel gets a one-cycle done pulse on expiry.

---
 rtl/parking_timer_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/parking_timer_sched.sv
// parking_timer_sched: shared 1 Hz timebase plus round-robin loaded countdown channels.
// Optional TIMER_PAUSE_EN adds a pause input that freezes the timebase and the countdown.
module parking_timer_sched #(
    parameter int CLK_HZ = 50_000_000,
    parameter int NUM_CH = 4,
    parameter int DUR_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*DUR_W-1:0] dur,
    input  logic [NUM_CH-1:0]       cancel,
`ifdef TIMER_PAUSE_EN
    input  logic                    pause,
`endif
    output logic [NUM_CH-1:0]       grant,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    tick_1hz
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int PTR_W = $clog2(NUM_CH);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_CH - 1);

    logic [PRE_W-1:0]  r_pre;
    logic              r_tick;
    logic [PTR_W-1:0]  r_ptr;
    logic [NUM_CH-1:0] r_grant;
    logic [NUM_CH-1:0] r_busy;
    logic [NUM_CH-1:0] r_done;
    logic [DUR_W-1:0]  r_cnt [NUM_CH];

    logic              w_pause;
    logic              w_wrap;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_gnt;
    logic              w_found;
    logic [PTR_W-1:0]  w_gidx;
    logic [PTR_W-1:0]  w_cand;

`ifdef TIMER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_wrap = (r_pre == PRE_MAX);

    // A channel still showing its grant is held off so a lingering req is not re-granted.
    assign w_elig = req & ~r_busy & ~cancel & ~r_grant;

    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_cand  = r_ptr;
        for (int j = 1; j <= NUM_CH; j++) begin
            w_cand = PTR_W'((int'(r_ptr) + j) % NUM_CH);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
        w_gnt[w_gidx] = w_found;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_ptr   <= PTR_RST;
            r_grant <= '0;
            r_busy  <= '0;
            r_done  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (!w_pause) begin
                r_pre <= w_wrap ? '0 : r_pre + 1'b1;
            end
            r_tick  <= w_wrap && !w_pause;
            r_grant <= w_gnt;
            if (w_found) begin
                r_ptr <= w_gidx;
            end
            // A tick already issued before pause rose is still consumed.
            for (int i = 0; i < NUM_CH; i++) begin
                r_done[i] <= 1'b0;
                if (r_busy[i] && cancel[i]) begin
                    r_busy[i] <= 1'b0;
                    r_cnt[i]  <= '0;
                end else if (r_busy[i] && r_tick && r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                    if (r_cnt[i] == DUR_W'(1)) begin
                        r_busy[i] <= 1'b0;
                        r_done[i] <= 1'b1;
                    end
                end else if (w_gnt[i]) begin
                    if (dur[i*DUR_W +: DUR_W] == '0) begin
                        r_done[i] <= 1'b1;
                    end else begin
                        r_cnt[i]  <= dur[i*DUR_W +: DUR_W];
                        r_busy[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign grant    = r_grant;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tick_1hz = r_tick;

endmodule
